tick_delay_scheduler: RTL
=========================

# tick_delay_scheduler

Multi-channel delay scheduler built around one shared tick prescaler. Up to CH requesters each arm a delay, counted in prescaler ticks. Expirations are serialized onto a single event port with fixed priority and a valid/ready handshake. It sits between the CLK50MHZ domain's slow-timing consumers (debouncers, LCD/PS2 timeouts, blinkers) so they share one divider instead of each instantiating its own.

## Interface
- PRESCALE, 50: CLK50MHZ cycles per tick; legal range 2..2^16.
- CH, 4: number of requester channels; legal range 2..16.
- DW, 8: delay field width in ticks.
- CLK50MHZ  in  1  system clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- req  in  CH  per-channel arm request, level-sampled each cycle.
- delay  in  CH*DW  per-channel delay; channel i uses bits [i*DW +: DW].
- busy  out  CH  channel i not IDLE.
- tick  out  1  one-cycle pulse every PRESCALE cycles.
- evt_valid  out  1  at least one channel has an event pending.
- evt_id  out  IDW  index of the presented channel; IDW = ceil(log2(CH)), computed by a constant function.
- evt_ready  in  1  consumer accepts the event.

## Operation
- Prescaler:
  - Counter 0..PRESCALE-1, free-running from reset; wraps to 0 after PRESCALE-1.
  - tick = (counter == PRESCALE-1), combinational from the registered counter.
  - Counter width = ceil(log2(PRESCALE)), via the same constant function.
- Per-channel state: IDLE, COUNT, PEND. Each channel also holds a DW-bit remaining register.
- IDLE:
  - If req[i]=1 and delay≠0: load remaining=delay, go to COUNT.
  - If req[i]=1 and delay=0: go straight to PEND.
  - req[i] is ignored in COUNT and PEND; the arming is not queued.
- COUNT: on a cycle with tick=1, decrement remaining. If remaining==1 on that tick, go to PEND instead.
- PEND: holds until its event is accepted (evt_valid & evt_ready with evt_id==i), then goes to IDLE.
- Event port (combinational from the state registers):
  - evt_valid = OR of all PEND flags.
  - evt_id = lowest-index PEND channel; evt_id = 0 when evt_valid=0.
  - At most one event is accepted per cycle.
- busy[i] = (state≠IDLE), registered-state decode.
- Arithmetic: remaining never wraps, since decrement occurs only when remaining≥2. The maximum delay is 2^DW-1 ticks.

## Timing
- Reset values: counter=0, all channels IDLE, remaining=0, busy=0, tick=0, evt_valid=0, evt_id=0.
- After RST falls, the first tick occurs PRESCALE cycles later (counter reaches PRESCALE-1), then every PRESCALE cycles.
- Arming latency: req sampled at edge t sets busy=1 in cycle t+1.
- A tick coinciding with the acceptance cycle does not count. The first counted tick is strictly after acceptance.
- Delay D≥1: PEND (evt_valid for that channel) starts in the cycle after the D-th counted tick. Total latency from acceptance is between (D-1)*PRESCALE+1 and D*PRESCALE cycles.
- Delay 0: evt_valid in cycle t+1.
- After acceptance at edge t, the channel is IDLE (busy=0) in cycle t+1. It can re-arm in cycle t+1 at the earliest, never in the same cycle as acceptance.
- Simultaneous expiries: all move to PEND on the same edge and are drained lowest-first, one per evt_ready cycle.
- While evt_valid=1 and evt_ready=0, evt_id is stable unless a lower-index channel enters PEND. Lower index then preempts; this is the sole allowed change.
- evt_ready while evt_valid=0 has no effect.
- RST mid-operation: all counting and pending state is discarded and the next cycle equals the post-reset state. No event is emitted for discarded channels.

## Test plan
- Reset, no requests, PRESCALE=4: tick high in cycles 4, 8, 12 after RST release. busy=0 and evt_valid=0 throughout.
- req[0]=1 with delay=3 for one cycle, evt_ready=1: busy[0]=1 next cycle. evt_valid=1 with evt_id=0 in the cycle after the 3rd subsequent tick, for exactly one cycle. busy[0]=0 the cycle after.
- req[2] with delay=0: evt_valid=1, evt_id=2 one cycle after the request. A tick in between has no effect.
- req[1] and req[3] in the same cycle, both delay=2, evt_ready=1: evt_id=1 then evt_id=3 in consecutive cycles after the 2nd tick. Both busy bits clear in order.
- Channel 0 pending with evt_ready=0 for 10 cycles, req[0] pulsed with delay=5 meanwhile: evt_valid and evt_id=0 stay stable and the re-request is ignored. After evt_ready=1, one event is accepted and busy[0]=0.
- Channel 1 armed with delay=200, RST asserted one cycle at tick 50: all busy=0 and the counter restarts at 0. No event appears for channel 1 within 300 ticks.

Source files
------------

// File: rtl/tick_delay_scheduler.sv
// tick_delay_scheduler: shared tick prescaler feeding CH one-shot delay channels,
// whose expirations are serialized lowest-index-first onto one valid/ready event port.
package tick_delay_scheduler_pkg;
    function automatic int clog2c(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

module tick_delay_scheduler
    import tick_delay_scheduler_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter int CH = 4,
    parameter int DW = 8,
    localparam int IDW = clog2c(CH),
    localparam int CW = clog2c(PRESCALE)
) (
    input  logic             CLK50MHZ,
    input  logic             RST,
    input  logic [CH-1:0]    req,
    input  logic [CH*DW-1:0] delay,
    output logic [CH-1:0]    busy,
    output logic             tick,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    input  logic             evt_ready
);
    typedef enum logic [1:0] {IDLE, COUNT, PEND} state_t;

    state_t        st [CH];
    logic [DW-1:0] rem [CH];
    logic [CW-1:0] cnt;
    logic [CH-1:0] pend;
    logic          acc;

    assign tick = cnt == CW'(PRESCALE - 1);
    assign evt_valid = |pend;
    assign acc = evt_valid & evt_ready;

    always_comb begin
        pend = '0;
        busy = '0;
        evt_id = '0;
        for (int i = 0; i < CH; i++) begin
            pend[i] = st[i] == PEND;
            busy[i] = st[i] != IDLE;
        end
        for (int i = CH - 1; i >= 0; i--) if (pend[i]) evt_id = IDW'(i);
    end

    // A channel leaving COUNT keeps remaining at 1, so it never wraps
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            cnt <= '0;
            for (int i = 0; i < CH; i++) begin
                st[i] <= IDLE;
                rem[i] <= '0;
            end
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            for (int i = 0; i < CH; i++) begin
                if (st[i] == IDLE && req[i]) begin
                    st[i] <= delay[i*DW +: DW] == '0 ? PEND : COUNT;
                    rem[i] <= delay[i*DW +: DW];
                end else if (st[i] == COUNT && tick) begin
                    st[i] <= rem[i] == DW'(1) ? PEND : COUNT;
                    rem[i] <= rem[i] == DW'(1) ? rem[i] : rem[i] - DW'(1);
                end else if (st[i] == PEND && acc && evt_id == IDW'(i)) begin
                    st[i] <= IDLE;
                end
            end
        end
    end
endmodule
